jesd204b_rx_cgs_ctrl_ml: RTL and testbench
==========================================

Name: jesd204b_rx_cgs_ctrl_ml

Overview:
Multi-lane JESD204B receive link controller, placed between the per-lane transceiver RX outputs and user logic.
- Per lane: comma alignment by pulsing the transceiver slide input, then code-group synchronisation (CGS) lock.
- Link level: SYSREF-aligned LMFC counter; o_nsync released on an LMFC boundary once all lanes lock.
- Lane data forwarded with a valid flag.
- Generalises the single-lane slide controller to NUM_LANES lanes with configurable K/F.

Parameters:
- NUM_LANES, 4, number of lanes.
- USERDATA_WIDTH, 32, bits per lane per i_usrclk; fixed at 4 octets.
- K_FRAMES, 32, frames per multiframe.
- F_OCTETS, 1, octets per frame. Constraint: K_FRAMES*F_OCTETS divisible by 4.
- FMLC_CNT_WIDTH, 8, LMFC counter width. Must hold LMFC_PERIOD-1.
- SLIDE_GAP, 32, idle cycles after each slide pulse.
- CGS_K_MIN, 4, consecutive good comma words needed for lane lock.
- LOSS_ERR, 3, consecutive errored words that drop lane lock.

Ports:
- i_usrclk, in, 1, single clock for all logic.
- i_rst_n, in, 1, asynchronous active-low reset.
- i_link_en, in, 1, link enable.
- i_sysref, in, 1, SYSREF, already synchronous to i_usrclk.
- i_rx_data, in, NUM_LANES*32, lane words; lane n at [32n+31:32n], octet0 = LSB.
- i_rx_charisk, in, NUM_LANES*4, K-flag per octet.
- i_rx_err, in, NUM_LANES*4, disparity or not-in-table flag per octet.
- o_rxslide, out, NUM_LANES, one-cycle slide request per lane.
- o_lane_locked, out, NUM_LANES, per-lane CGS lock.
- o_nsync, out, 1, active-low sync request.
- o_lmfc_cnt, out, FMLC_CNT_WIDTH, LMFC phase.
- o_lmfc_edge, out, 1, high when o_lmfc_cnt==0.
- o_sysref_seen, out, 1, sticky flag.
- o_data, out, NUM_LANES*32, registered lane data.
- o_data_valid, out, 1, user data valid.

Behaviour:
- Reset: all outputs 0, except o_nsync=1'b0 (sync requested). Lane FSMs go to HUNT, link FSM to SYNC, LMFC counter to 0.
- Definitions:
  - "comma word": charisk nibble=4'hF and data=32'hBCBCBCBC.
  - "errored word": any i_rx_err bit set.
- Lane FSM (per lane, independent):
  - HUNT: on comma word, go to CHECK with count=1. Otherwise pulse o_rxslide for 1 cycle and go to SLIDE_WAIT.
  - SLIDE_WAIT: count SLIDE_GAP cycles, ignoring data, then go to HUNT.
  - CHECK: each comma word increments count. When count reaches CGS_K_MIN, go to LOCKED. Any non-comma word goes to HUNT; this word does not itself trigger a slide.
  - LOCKED: o_lane_locked=1. Error count increments on an errored word and clears on a clean word. Reaching LOSS_ERR goes to HUNT. Lock is kept on non-comma clean words.
  - i_link_en=0 forces all lanes to HUNT with no slides issued.
- LMFC:
  - LMFC_PERIOD = K_FRAMES*F_OCTETS/4 cycles.
  - Counter increments each cycle and wraps from PERIOD-1 to 0.
  - A rising edge of i_sysref (registered compare) forces the counter to 0 on the next cycle and sets o_sysref_seen.
  - Simultaneous wrap and SYSREF: SYSREF wins; the result is 0 either way.
  - o_lmfc_cnt and o_lmfc_edge are registered.
- Link FSM:
  - SYNC: o_nsync=0. When all o_lane_locked=1, i_link_en=1 and o_sysref_seen=1, go to WAIT_LMFC.
  - WAIT_LMFC: o_nsync=0. On o_lmfc_edge, go to ILAS; o_nsync=1 from the next cycle.
  - ILAS: o_nsync=1. In the first cycle where every lane presents a non-comma word, go to DATA.
  - DATA: o_data_valid=1.
  - Any lane dropping lock, or i_link_en=0, from WAIT_LMFC/ILAS/DATA: go to SYNC. o_nsync=0 and o_data_valid=0 on the next cycle.
- Data path:
  - o_data = i_rx_data delayed 1 cycle, unconditionally.
  - o_data_valid is aligned to o_data: it is high on the cycle carrying the first all-lanes-non-comma word.
- No lane deskew; lanes are assumed aligned to within a word.
- Reset mid-operation: outputs return to reset values immediately (asynchronously).

Test Plan:
1. Aligned commas, 4 lanes, SYSREF pulse at cycle 20 → o_rxslide never asserts; o_lane_locked=4'hF four cycles after the first comma word; o_nsync rises the cycle after the first o_lmfc_edge following lock (period 8).
2. Lane 2 data rotated by one octet (32'hBCBCBC00 pattern) → o_rxslide[2] pulses exactly once per SLIDE_GAP+1 cycles until the source is realigned; other lanes lock normally; o_nsync stays 0 until lane 2 locks.
3. No SYSREF issued, all lanes locked → o_nsync stays 0 indefinitely. Then pulse i_sysref → o_lmfc_cnt=0 next cycle, o_sysref_seen=1, o_nsync=1 after the next edge.
4. In DATA, inject errors on lane 0 for 3 consecutive cycles → o_lane_locked[0]=0 and o_nsync=0 on the following cycle. With only 2 errors followed by a clean word, the link stays up.
5. After nsync release, lanes switch to 32'h1C... words with charisk=4'h1 → o_data_valid=1 coincident with o_data=32'h...1C; o_data matches i_rx_data delayed by 1 cycle throughout.
6. Assert i_rst_n=0 mid-DATA → o_nsync=0, o_data_valid=0, o_lmfc_cnt=0 immediately. Deassert → full re-lock sequence as in scenario 1.

Source files
------------

// File: rtl/jesd204b_rx_cgs_ctrl_ml.sv
// rtl/jesd204b_rx_cgs_ctrl_ml.sv - multi-lane JESD204B RX comma alignment, CGS lock, LMFC and nsync control
// Each lane slides until commas line up and locks after CGS_K_MIN good commas; the link releases nsync on an LMFC edge.
module jesd204b_rx_cgs_ctrl_ml #(
  parameter int NUM_LANES      = 4,
  parameter int USERDATA_WIDTH = 32,
  parameter int K_FRAMES       = 32,
  parameter int F_OCTETS       = 1,
  parameter int FMLC_CNT_WIDTH = 8,
  parameter int SLIDE_GAP      = 32,
  parameter int CGS_K_MIN      = 4,
  parameter int LOSS_ERR       = 3
) (
  input  logic                                  i_usrclk,
  input  logic                                  i_rst_n,
  input  logic                                  i_link_en,
  input  logic                                  i_sysref,
  input  logic [NUM_LANES*USERDATA_WIDTH-1:0]   i_rx_data,
  input  logic [NUM_LANES*USERDATA_WIDTH/8-1:0] i_rx_charisk,
  input  logic [NUM_LANES*USERDATA_WIDTH/8-1:0] i_rx_err,
  output logic [NUM_LANES-1:0]                  o_rxslide,
  output logic [NUM_LANES-1:0]                  o_lane_locked,
  output logic                                  o_nsync,
  output logic [FMLC_CNT_WIDTH-1:0]             o_lmfc_cnt,
  output logic                                  o_lmfc_edge,
  output logic                                  o_sysref_seen,
  output logic [NUM_LANES*USERDATA_WIDTH-1:0]   o_data,
  output logic                                  o_data_valid
);
  localparam int OCTETS      = USERDATA_WIDTH / 8;
  localparam int LMFC_PERIOD = K_FRAMES * F_OCTETS / 4;
  localparam int CW          = $clog2(SLIDE_GAP + CGS_K_MIN + LOSS_ERR + 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(SLIDE_GAP - 1);
  localparam logic [CW-1:0] KMIN_LAST = CW'(CGS_K_MIN - 1);
  localparam logic [CW-1:0] ERR_LAST  = CW'(LOSS_ERR - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [FMLC_CNT_WIDTH-1:0] LMFC_LAST = FMLC_CNT_WIDTH'(LMFC_PERIOD - 1);
  localparam logic [FMLC_CNT_WIDTH-1:0] LMFC_ONE  = FMLC_CNT_WIDTH'(1);
  localparam logic [USERDATA_WIDTH-1:0] COMMA_WORD = {OCTETS{8'hBC}};

  typedef enum logic [1:0] {L_HUNT, L_SLIDE_WAIT, L_CHECK, L_LOCKED} lane_st_e;
  typedef enum logic [1:0] {K_SYNC, K_WAIT_LMFC, K_ILAS, K_DATA} link_st_e;

  logic [NUM_LANES-1:0] is_comma;
  logic [NUM_LANES-1:0] lose;

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    lane_st_e        st_q;
    logic [CW-1:0]   cnt_q;
    logic            slide_q;
    logic            locked_q;
    logic            is_err;

    assign is_comma[n] = (i_rx_charisk[n*OCTETS +: OCTETS] == {OCTETS{1'b1}}) &&
                         (i_rx_data[n*USERDATA_WIDTH +: USERDATA_WIDTH] == COMMA_WORD);
    assign is_err      = |i_rx_err[n*OCTETS +: OCTETS];
    // Lets the link fall back to SYNC on the same edge the lane loses lock.
    assign lose[n]     = (st_q == L_LOCKED) && is_err && (cnt_q == ERR_LAST);
    assign o_rxslide[n]     = slide_q;
    assign o_lane_locked[n] = locked_q;

    // cnt_q is shared: slide gap in SLIDE_WAIT, comma run in CHECK, error run in LOCKED.
    always_ff @(posedge i_usrclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        st_q     <= L_HUNT;
        cnt_q    <= '0;
        slide_q  <= 1'b0;
        locked_q <= 1'b0;
      end else begin
        slide_q <= 1'b0;
        if (!i_link_en) begin
          st_q     <= L_HUNT;
          cnt_q    <= '0;
          locked_q <= 1'b0;
        end else begin
          case (st_q)
            L_HUNT: begin
              if (is_comma[n]) begin
                st_q  <= L_CHECK;
                cnt_q <= CNT_ONE;
              end else begin
                st_q    <= L_SLIDE_WAIT;
                cnt_q   <= '0;
                slide_q <= 1'b1;
              end
            end
            L_SLIDE_WAIT: begin
              if (cnt_q == GAP_LAST) begin
                st_q  <= L_HUNT;
                cnt_q <= '0;
              end else begin
                cnt_q <= cnt_q + CNT_ONE;
              end
            end
            L_CHECK: begin
              if (!is_comma[n]) begin
                st_q  <= L_HUNT;
                cnt_q <= '0;
              end else if (cnt_q == KMIN_LAST) begin
                st_q     <= L_LOCKED;
                cnt_q    <= '0;
                locked_q <= 1'b1;
              end else begin
                cnt_q <= cnt_q + CNT_ONE;
              end
            end
            L_LOCKED: begin
              if (!is_err) begin
                cnt_q <= '0;
              end else if (cnt_q == ERR_LAST) begin
                st_q     <= L_HUNT;
                cnt_q    <= '0;
                locked_q <= 1'b0;
              end else begin
                cnt_q <= cnt_q + CNT_ONE;
              end
            end
            default: st_q <= L_HUNT;
          endcase
        end
      end
    end
  end

  logic                      sysref_q;
  logic                      sysref_rise;
  logic [FMLC_CNT_WIDTH-1:0] lmfc_cnt_q;
  logic [FMLC_CNT_WIDTH-1:0] lmfc_cnt_d;
  logic                      lmfc_edge_q;
  logic                      sysref_seen_q;

  assign sysref_rise = i_sysref && !sysref_q;
  assign lmfc_cnt_d  = (sysref_rise || lmfc_cnt_q == LMFC_LAST) ? '0 : lmfc_cnt_q + LMFC_ONE;

  always_ff @(posedge i_usrclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sysref_q      <= 1'b0;
      lmfc_cnt_q    <= '0;
      lmfc_edge_q   <= 1'b0;
      sysref_seen_q <= 1'b0;
    end else begin
      sysref_q    <= i_sysref;
      lmfc_cnt_q  <= lmfc_cnt_d;
      lmfc_edge_q <= (lmfc_cnt_d == '0);
      if (sysref_rise) sysref_seen_q <= 1'b1;
    end
  end

  link_st_e                              link_st_q;
  logic                                  nsync_q;
  logic                                  valid_q;
  logic [NUM_LANES*USERDATA_WIDTH-1:0]   data_q;
  logic                                  link_drop;

  assign link_drop = !i_link_en || !(&o_lane_locked) || (|lose);

  always_ff @(posedge i_usrclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      link_st_q <= K_SYNC;
      nsync_q   <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
    end else begin
      data_q <= i_rx_data;
      case (link_st_q)
        K_SYNC: begin
          if ((&o_lane_locked) && i_link_en && sysref_seen_q) link_st_q <= K_WAIT_LMFC;
        end
        K_WAIT_LMFC: begin
          if (link_drop) begin
            link_st_q <= K_SYNC;
          end else if (lmfc_edge_q) begin
            link_st_q <= K_ILAS;
            nsync_q   <= 1'b1;
          end
        end
        K_ILAS: begin
          if (link_drop) begin
            link_st_q <= K_SYNC;
            nsync_q   <= 1'b0;
          end else if (is_comma == '0) begin
            link_st_q <= K_DATA;
            valid_q   <= 1'b1;
          end
        end
        K_DATA: begin
          if (link_drop) begin
            link_st_q <= K_SYNC;
            nsync_q   <= 1'b0;
            valid_q   <= 1'b0;
          end
        end
        default: link_st_q <= K_SYNC;
      endcase
    end
  end

  assign o_nsync       = nsync_q;
  assign o_data_valid  = valid_q;
  assign o_data        = data_q;
  assign o_lmfc_cnt    = lmfc_cnt_q;
  assign o_lmfc_edge   = lmfc_edge_q;
  assign o_sysref_seen = sysref_seen_q;
endmodule

// File: tb/tb_jesd204b_rx_cgs_ctrl_ml.sv
// tb/tb_jesd204b_rx_cgs_ctrl_ml.sv - scoreboard bench for jesd204b_rx_cgs_ctrl_ml
// Stimulus pushes time-stamped expectations and expected valid data words; a monitor pops and compares.
module tb_jesd204b_rx_cgs_ctrl_ml;
  logic         i_usrclk;
  logic         i_rst_n;
  logic         i_link_en;
  logic         i_sysref;
  logic [127:0] i_rx_data;
  logic [15:0]  i_rx_charisk;
  logic [15:0]  i_rx_err;
  logic [3:0]   o_rxslide;
  logic [3:0]   o_lane_locked;
  logic         o_nsync;
  logic [7:0]   o_lmfc_cnt;
  logic         o_lmfc_edge;
  logic         o_sysref_seen;
  logic [127:0] o_data;
  logic         o_data_valid;

  jesd204b_rx_cgs_ctrl_ml dut (
    .i_usrclk(i_usrclk), .i_rst_n(i_rst_n), .i_link_en(i_link_en), .i_sysref(i_sysref),
    .i_rx_data(i_rx_data), .i_rx_charisk(i_rx_charisk), .i_rx_err(i_rx_err),
    .o_rxslide(o_rxslide), .o_lane_locked(o_lane_locked), .o_nsync(o_nsync),
    .o_lmfc_cnt(o_lmfc_cnt), .o_lmfc_edge(o_lmfc_edge), .o_sysref_seen(o_sysref_seen),
    .o_data(o_data), .o_data_valid(o_data_valid)
  );

  localparam logic [127:0] COMMA   = {4{32'hBCBCBCBC}};
  localparam logic [15:0]  K_COMMA = 16'hFFFF;
  localparam int F_LOCKED = 0, F_NSYNC = 1, F_VALID = 2, F_SLIDE = 3;
  localparam int F_CNT = 4, F_EDGE = 5, F_SEEN = 6, F_DATA = 7;

  typedef struct {
    int           cyc;
    int           fld;
    logic [127:0] val;
    string        name;
  } exp_t;

  exp_t         exp_q[$];
  logic [127:0] data_q[$];
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;

  initial i_usrclk = 1'b0;
  always #5 i_usrclk = ~i_usrclk;
  always @(posedge i_usrclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
    end
  endtask

  function automatic logic [127:0] get_fld(input int f);
    case (f)
      F_LOCKED: return 128'(o_lane_locked);
      F_NSYNC:  return 128'(o_nsync);
      F_VALID:  return 128'(o_data_valid);
      F_SLIDE:  return 128'(o_rxslide);
      F_CNT:    return 128'(o_lmfc_cnt);
      F_EDGE:   return 128'(o_lmfc_edge);
      F_SEEN:   return 128'(o_sysref_seen);
      default:  return o_data;
    endcase
  endfunction

  // Expectation applies to the outputs just after the upcoming clock edge.
  task automatic push_exp(input int f, input logic [127:0] v, input string name);
    exp_t e;
    e.cyc = cyc + 1; e.fld = f; e.val = v; e.name = name;
    exp_q.push_back(e);
  endtask

  always @(posedge i_usrclk) begin : monitor
    exp_t e;
    #2;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      chk(e.name, get_fld(e.fld), e.val);
    end
    if (o_data_valid) begin
      if (data_q.size() == 0) chk("data_sb_unexpected_valid", 128'(o_data_valid), 128'd0);
      else chk("data_sb", o_data, data_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic step(input logic [127:0] d, input logic [15:0] k, input logic [15:0] e,
                      input logic sr, input logic rst);
    @(negedge i_usrclk);
    i_rx_data = d; i_rx_charisk = k; i_rx_err = e; i_sysref = sr; i_rst_n = rst;
  endtask

  function automatic logic [127:0] user_word(input int t);
    logic [127:0] d;
    for (int n = 0; n < 4; n++) d[n*32 +: 32] = {8'(t), 8'(n), 8'h5A, 8'h1C};
    return d;
  endfunction

  task automatic reset_seq();
    for (int i = 0; i < 2; i++) begin
      step(COMMA, K_COMMA, 16'h0, 1'b0, 1'b0);
      push_exp(F_LOCKED, 0, "rst_locked");
      push_exp(F_NSYNC, 0, "rst_nsync");
      push_exp(F_VALID, 0, "rst_valid");
      push_exp(F_SLIDE, 0, "rst_slide");
      push_exp(F_CNT, 0, "rst_lmfc_cnt");
      push_exp(F_EDGE, 0, "rst_lmfc_edge");
      push_exp(F_SEEN, 0, "rst_sysref_seen");
      push_exp(F_DATA, 0, "rst_data");
    end
  endtask

  // Aligned commas from reset release (t=1); lock lands at t=4, nsync rises at sr_at+9.
  task automatic bringup(input int sr_at, input int t_end);
    int c;
    for (int t = 1; t <= t_end; t++) begin
      step(COMMA, K_COMMA, 16'h0, t == sr_at, 1'b1);
      c = (t < sr_at) ? t % 8 : (t - sr_at) % 8;
      push_exp(F_SLIDE, 0, "bu_slide");
      push_exp(F_LOCKED, (t >= 4) ? 128'hF : 128'h0, "bu_locked");
      push_exp(F_NSYNC, 128'(t >= sr_at + 9), "bu_nsync");
      push_exp(F_VALID, 0, "bu_valid");
      push_exp(F_SEEN, 128'(t >= sr_at), "bu_sysref_seen");
      push_exp(F_CNT, 128'(c), "bu_lmfc_cnt");
      push_exp(F_EDGE, 128'(c == 0), "bu_lmfc_edge");
      push_exp(F_DATA, COMMA, "bu_data");
    end
  endtask

  // User words from t0; lane 0 errored for e_cnt edges starting at e_first.
  task automatic data_phase(input int t0, input int t_end, input int e_first, input int e_cnt);
    int  drop_t;
    logic dropped;
    drop_t = (e_cnt >= 3) ? e_first + 2 : 1 << 30;
    for (int t = t0; t <= t_end; t++) begin
      step(user_word(t), 16'h1111, (t >= e_first && t < e_first + e_cnt) ? 16'h0001 : 16'h0,
           1'b0, 1'b1);
      dropped = (t >= drop_t);
      push_exp(F_LOCKED, dropped ? 128'hE : 128'hF, "dp_locked");
      push_exp(F_NSYNC, 128'(!dropped), "dp_nsync");
      push_exp(F_VALID, 128'(!dropped), "dp_valid");
      push_exp(F_SLIDE, (t == drop_t + 1) ? 128'h1 : 128'h0, "dp_slide");
      push_exp(F_DATA, user_word(t), "dp_data_delay");
      if (!dropped) data_q.push_back(user_word(t));
    end
  endtask

  // Lane 2 rotated by one octet: slides at t=1,34,67, realigned after 67, lock at 103, nsync at 107.
  task automatic rotated_lane();
    logic [127:0] d;
    logic [15:0]  k;
    for (int t = 1; t <= 110; t++) begin
      d = COMMA; k = K_COMMA;
      if (t <= 67) begin
        d[95:64] = 32'hBCBCBC00;
        k = 16'hFEFF;
      end
      step(d, k, 16'h0, t == 10, 1'b1);
      push_exp(F_SLIDE, (t == 1 || t == 34 || t == 67) ? 128'h4 : 128'h0, "rot_slide");
      push_exp(F_LOCKED, (t >= 103) ? 128'hF : ((t >= 4) ? 128'hB : 128'h0), "rot_locked");
      push_exp(F_NSYNC, 128'(t >= 107), "rot_nsync");
      push_exp(F_DATA, d, "rot_data");
    end
  endtask

  initial begin
    i_rst_n = 1'b0; i_link_en = 1'b1; i_sysref = 1'b0;
    i_rx_data = COMMA; i_rx_charisk = K_COMMA; i_rx_err = 16'h0;

    reset_seq();
    bringup(18, 30);
    data_phase(31, 37, 34, 2);

    @(posedge i_usrclk);
    #4 i_rst_n = 1'b0;
    #1;
    chk("async_rst_nsync", 128'(o_nsync), 128'd0);
    chk("async_rst_valid", 128'(o_data_valid), 128'd0);
    chk("async_rst_lmfc_cnt", 128'(o_lmfc_cnt), 128'd0);
    chk("async_rst_locked", 128'(o_lane_locked), 128'd0);

    reset_seq();
    bringup(18, 30);
    data_phase(31, 40, 34, 3);

    reset_seq();
    bringup(41, 52);

    reset_seq();
    rotated_lane();

    repeat (3) @(negedge i_usrclk);
    chk("exp_queue_drained", 128'(exp_q.size()), 128'd0);
    chk("data_queue_drained", 128'(data_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
